// File: rtl/bcd_7seg_scanner.sv
// Four-digit multiplexed 7-segment driver fed by packed BCD over valid/ready; new values commit only at frame end.
// Optional BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bcd_7seg_scanner #(
  parameter int CLK_DIV = 100000,
  parameter int DIV_W   = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bcd_valid,
  input  logic [15:0] bcd_in,
  output logic        bcd_ready,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame_start
);

  // state | meaning
  // DIG0  | units digit selected
  // DIG1  | tens digit selected
  // DIG2  | hundreds digit selected
  // DIG3  | thousands digit selected; its last tick is the frame end
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt;
  logic [15:0]       disp;
  logic [15:0]       pend;
  logic              pend_full;

  logic              tick;
  logic              frame_end;
  logic              xfer;
  logic              commit;
  logic [1:0]        digit;
  logic [3:0]        nib;
  logic [3:0]        an_d;
  logic [6:0]        seg_d;

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick      = (div_cnt == DIV_MAX);
  assign frame_end = tick && (state_q == DIG3);
  assign bcd_ready = ~pend_full & ~rst;
  assign xfer      = bcd_valid && bcd_ready;
  assign commit    = frame_end && pend_full;
  assign digit     = state_q;

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        default: state_d = DIG0;
      endcase
    end
  end

  always_comb begin
    nib   = disp[{digit, 2'b00} +: 4];
    an_d  = ~(4'b0001 << digit);
    seg_d = enc(nib);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    // A digit is blank only if it and every higher digit are literal zero nibbles.
    case (digit)
      2'd3:    if (disp[15:12] == 4'h0) seg_d = 7'h7F;
      2'd2:    if (disp[15:8]  == 8'h00) seg_d = 7'h7F;
      2'd1:    if (disp[15:4]  == 12'h000) seg_d = 7'h7F;
      default: seg_d = enc(nib);
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIG0;
      div_cnt     <= '0;
      disp        <= 16'h0000;
      pend        <= 16'h0000;
      pend_full   <= 1'b0;
      an_n        <= 4'b1111;
      seg_n       <= 7'h7F;
      frame_start <= 1'b0;
    end else begin
      state_q <= state_d;
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      // Commit and transfer are exclusive: one needs pend_full set, the other clear.
      if (commit) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (xfer) begin
        pend      <= bcd_in;
        pend_full <= 1'b1;
      end
      an_n        <= an_d;
      seg_n       <= seg_d;
      frame_start <= (state_q == DIG0) && (an_n != 4'b1110);
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Directed bench for bcd_7seg_scanner with CLK_DIV=4 (16-cycle frames).
// Expected leading-zero segments follow BCD_LEADING_ZERO_BLANK_EN.
module tb_bcd_7seg_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bcd_valid = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic        bcd_ready;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  bcd_7seg_scanner #(.CLK_DIV(4), .DIV_W(17)) dut (
    .clk(clk),
    .rst(rst),
    .bcd_valid(bcd_valid),
    .bcd_in(bcd_in),
    .bcd_ready(bcd_ready),
    .seg_n(seg_n),
    .an_n(an_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 48; k++) begin
      step();
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({an_n, seg_n, frame_start, bcd_ready} !== {4'b1111, 7'h7F, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: an=%b seg=%h fs=%b rdy=%b, want an=1111 seg=7f fs=0 rdy=0",
                 k, an_n, seg_n, frame_start, bcd_ready);
      end
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({an_n, seg_n, frame_start, bcd_ready} !== {4'b1110, 7'h40, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_release: an=%b seg=%h fs=%b rdy=%b, want an=1110 seg=40 fs=1 rdy=1",
               an_n, seg_n, frame_start, bcd_ready);
    end
  endtask

  task automatic test_scan();
    logic [6:0] es [4];
    logic [3:0] ea;
    bit ok;
    es[0] = 7'h19; es[1] = 7'h30; es[2] = 7'h24; es[3] = 7'h79;
    bcd_valid = 1'b1;
    bcd_in    = 16'h1234;
    step();
    bcd_valid = 1'b0;
    n_cmp++;
    if (bcd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL scan_ready_drop: rdy=%b, want 0", bcd_ready);
    end
    wait_fs(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL scan_wait_frame: timeout, want frame_start");
    end
    for (int i = 0; i < 16; i++) begin
      ea = ~(4'b0001 << (i / 4));
      n_cmp++;
      if ({an_n, seg_n, frame_start} !== {ea, es[i/4], (i == 0)}) begin
        n_bad++;
        $display("FAIL scan_1234 cyc%0d: an=%b seg=%h fs=%b, want an=%b seg=%h fs=%b",
                 i, an_n, seg_n, frame_start, ea, es[i/4], (i == 0));
      end
      step();
    end
  endtask

  task automatic test_handshake();
    logic [6:0] es [4];
    logic [3:0] ea;
    bit ok;
    bit last_rdy;
    int n_rdy;
    es[0] = 7'h00; es[1] = 7'h78; es[2] = 7'h02; es[3] = 7'h12;
    for (int k = 0; k < 5; k++) step();
    bcd_valid = 1'b1;
    bcd_in    = 16'h5678;
    n_cmp++;
    if (bcd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hs_ready_before: rdy=%b, want 1", bcd_ready);
    end
    step();
    bcd_in = 16'h9999;
    n_cmp++;
    if (bcd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_ready_after: rdy=%b, want 0", bcd_ready);
    end
    step();
    step();
    bcd_valid = 1'b0;
    ok = 1'b0;
    last_rdy = 1'b0;
    n_rdy = 0;
    for (int k = 0; k < 48; k++) begin
      step();
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
      last_rdy = bcd_ready;
      if (bcd_ready) n_rdy++;
    end
    n_cmp++;
    if (!ok || n_rdy != 1 || last_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL hs_ready_return: found=%0d ready_cycles=%0d last=%b, want found=1 ready_cycles=1 last=1",
               ok, n_rdy, last_rdy);
    end
    for (int i = 0; i < 16; i++) begin
      ea = ~(4'b0001 << (i / 4));
      n_cmp++;
      if ({an_n, seg_n, frame_start} !== {ea, es[i/4], (i == 0)}) begin
        n_bad++;
        $display("FAIL hs_5678 cyc%0d: an=%b seg=%h fs=%b, want an=%b seg=%h fs=%b",
                 i, an_n, seg_n, frame_start, ea, es[i/4], (i == 0));
      end
      step();
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] es [4];
    logic [3:0] ea;
    for (int k = 0; k < 14; k++) step();
    n_cmp++;
    if ({an_n, bcd_ready} !== {4'b0111, 1'b1}) begin
      n_bad++;
      $display("FAIL sim_position: an=%b rdy=%b, want an=0111 rdy=1", an_n, bcd_ready);
    end
    bcd_valid = 1'b1;
    bcd_in    = 16'h0007;
    step();
    bcd_valid = 1'b0;
    n_cmp++;
    if ({bcd_ready, frame_start} !== {1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL sim_capture: rdy=%b fs=%b, want rdy=0 fs=0", bcd_ready, frame_start);
    end
    step();
    es[0] = 7'h00; es[1] = 7'h78; es[2] = 7'h02; es[3] = 7'h12;
    for (int i = 0; i < 16; i++) begin
      ea = ~(4'b0001 << (i / 4));
      n_cmp++;
      if ({an_n, seg_n, frame_start} !== {ea, es[i/4], (i == 0)}) begin
        n_bad++;
        $display("FAIL sim_old_frame cyc%0d: an=%b seg=%h fs=%b, want an=%b seg=%h fs=%b",
                 i, an_n, seg_n, frame_start, ea, es[i/4], (i == 0));
      end
      step();
    end
    es[0] = 7'h78; es[1] = LZ; es[2] = LZ; es[3] = LZ;
    for (int i = 0; i < 16; i++) begin
      ea = ~(4'b0001 << (i / 4));
      n_cmp++;
      if ({an_n, seg_n, frame_start} !== {ea, es[i/4], (i == 0)}) begin
        n_bad++;
        $display("FAIL sim_0007 cyc%0d: an=%b seg=%h fs=%b, want an=%b seg=%h fs=%b",
                 i, an_n, seg_n, frame_start, ea, es[i/4], (i == 0));
      end
      step();
    end
  endtask

  task automatic test_invalid_blank();
    logic [6:0] es [4];
    logic [3:0] ea;
    bit ok;
    bcd_valid = 1'b1;
    bcd_in    = 16'h0A05;
    step();
    bcd_valid = 1'b0;
    wait_fs(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL inv_wait_frame: timeout, want frame_start");
    end
    es[0] = 7'h12; es[1] = 7'h40; es[2] = 7'h3F; es[3] = LZ;
    for (int i = 0; i < 16; i++) begin
      ea = ~(4'b0001 << (i / 4));
      n_cmp++;
      if ({an_n, seg_n} !== {ea, es[i/4]}) begin
        n_bad++;
        $display("FAIL inv_0a05 cyc%0d: an=%b seg=%h, want an=%b seg=%h",
                 i, an_n, seg_n, ea, es[i/4]);
      end
      step();
    end
    bcd_valid = 1'b1;
    bcd_in    = 16'h0042;
    step();
    bcd_valid = 1'b0;
    wait_fs(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL blank_wait_frame: timeout, want frame_start");
    end
    es[0] = 7'h24; es[1] = 7'h19; es[2] = LZ; es[3] = LZ;
    for (int i = 0; i < 16; i++) begin
      ea = ~(4'b0001 << (i / 4));
      n_cmp++;
      if ({an_n, seg_n} !== {ea, es[i/4]}) begin
        n_bad++;
        $display("FAIL blank_0042 cyc%0d: an=%b seg=%h, want an=%b seg=%h",
                 i, an_n, seg_n, ea, es[i/4]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] es [4];
    logic [3:0] ea;
    bit ok;
    bcd_valid = 1'b1;
    bcd_in    = 16'h9999;
    step();
    bcd_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (an_n == 4'b1011) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok || bcd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_setup: found_digit2=%0d rdy=%b, want found_digit2=1 rdy=0", ok, bcd_ready);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({an_n, seg_n, frame_start, bcd_ready} !== {4'b1111, 7'h7F, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_hold: an=%b seg=%h fs=%b rdy=%b, want an=1111 seg=7f fs=0 rdy=0",
               an_n, seg_n, frame_start, bcd_ready);
    end
    step();
    rst = 1'b0;
    step();
    es[0] = 7'h40; es[1] = LZ; es[2] = LZ; es[3] = LZ;
    for (int i = 0; i < 32; i++) begin
      ea = ~(4'b0001 << ((i % 16) / 4));
      n_cmp++;
      if ({an_n, seg_n, frame_start, bcd_ready} !== {ea, es[(i%16)/4], ((i % 16) == 0), 1'b1}) begin
        n_bad++;
        $display("FAIL rstmid_0000 cyc%0d: an=%b seg=%h fs=%b rdy=%b, want an=%b seg=%h fs=%b rdy=1",
                 i, an_n, seg_n, frame_start, bcd_ready, ea, es[(i%16)/4], ((i % 16) == 0));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_handshake();
    test_simultaneous();
    test_invalid_blank();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
